// File: rtl/serv_rf_dbg_arb.sv
// serv_rf_dbg_arb: shares the serv RF RAM between the core and a debug host.
// Optional macro RF_DBG_ARB_ERR_EN adds o_dbg_err for rejected accesses.
module serv_rf_dbg_arb #(
  parameter int RF_WIDTH = 2,
  parameter int CSR_REGS = 4,
  parameter int RF_L2D   =
    $clog2((32 + CSR_REGS) * (32 / RF_WIDTH))
) (
  input  logic                clk,
  input  logic                i_rst_n,
  input  logic                i_core_rreq,
  input  logic                i_core_wreq,
  output logic                o_ifc_rreq,
  output logic                o_ifc_wreq,
  input  logic [RF_L2D-1:0]   i_ifc_waddr,
  input  logic [RF_WIDTH-1:0] i_ifc_wdata,
  input  logic                i_ifc_wen,
  input  logic [RF_L2D-1:0]   i_ifc_raddr,
  output logic [RF_L2D-1:0]   o_ram_waddr,
  output logic [RF_WIDTH-1:0] o_ram_wdata,
  output logic                o_ram_wen,
  output logic [RF_L2D-1:0]   o_ram_raddr,
  input  logic [RF_WIDTH-1:0] i_ram_rdata,
  output logic                o_halt_req,
  input  logic                i_halt_ack,
  input  logic                i_dbg_req,
  input  logic                i_dbg_we,
  input  logic [5:0]          i_dbg_reg,
  input  logic [31:0]         i_dbg_wdat,
  output logic [31:0]         o_dbg_rdt,
`ifdef RF_DBG_ARB_ERR_EN
  output logic                o_dbg_err,
`endif
  output logic                o_dbg_ack
);

  localparam int N      = 32 / RF_WIDTH;
  localparam int LN     = $clog2(N);
  localparam int BW     = LN + 1;
  localparam int MAXREG = 31 + CSR_REGS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_WR,
    S_RD,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [5:0]      reg_q, reg_d;
  logic [31:0]     wdat_q, wdat_d;
  logic [31:0]     rdt_q, rdt_d;
  logic            pend_r_q, pend_r_d;
  logic            pend_w_q, pend_w_d;
  logic            post_q, post_d;
  logic [RF_L2D-1:0] dbg_addr;
  logic            bad;
`ifdef RF_DBG_ARB_ERR_EN
  logic            err_q, err_d;
`endif

  assign dbg_addr = (RF_L2D'(reg_q) << LN)
                  + RF_L2D'(beat_q);

  assign bad = (int'(i_dbg_reg) > MAXREG)
            || (i_dbg_we && (i_dbg_reg == 6'd0));

  assign o_halt_req = (state_q == S_HALT)
                   || (state_q == S_WR)
                   || (state_q == S_RD);
  assign o_dbg_ack  = (state_q == S_DONE);
  assign o_dbg_rdt  = rdt_q;
`ifdef RF_DBG_ARB_ERR_EN
  assign o_dbg_err  = o_dbg_ack & err_q;
`endif

  // State, beat counter, captured request and replay flags
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      beat_q   <= '0;
      reg_q    <= '0;
      wdat_q   <= '0;
      rdt_q    <= '0;
      pend_r_q <= 1'b0;
      pend_w_q <= 1'b0;
      post_q   <= 1'b0;
`ifdef RF_DBG_ARB_ERR_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      reg_q    <= reg_d;
      wdat_q   <= wdat_d;
      rdt_q    <= rdt_d;
      pend_r_q <= pend_r_d;
      pend_w_q <= pend_w_d;
      post_q   <= post_d;
`ifdef RF_DBG_ARB_ERR_EN
      err_q    <= err_d;
`endif
    end
  end

  // Next state, RAM mux and core request hold-off/replay
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    reg_d       = reg_q;
    wdat_d      = wdat_q;
    rdt_d       = rdt_q;
    pend_r_d    = pend_r_q | i_core_rreq;
    pend_w_d    = pend_w_q | i_core_wreq;
    post_d      = 1'b0;
`ifdef RF_DBG_ARB_ERR_EN
    err_d       = err_q;
`endif
    o_ifc_rreq  = 1'b0;
    o_ifc_wreq  = 1'b0;
    o_ram_waddr = i_ifc_waddr;
    o_ram_wdata = i_ifc_wdata;
    o_ram_wen   = i_ifc_wen;
    o_ram_raddr = i_ifc_raddr;
    unique case (state_q)
      S_IDLE: begin
        o_ifc_rreq = i_core_rreq | pend_r_q;
        o_ifc_wreq = i_core_wreq | pend_w_q;
        pend_r_d   = 1'b0;
        pend_w_d   = 1'b0;
        if (i_dbg_req && !post_q)
          state_d = S_HALT;
      end
      S_HALT: begin
        if (i_halt_ack) begin
          rdt_d  = '0;
          beat_d = '0;
          if (bad) begin
            state_d = S_DONE;
`ifdef RF_DBG_ARB_ERR_EN
            err_d   = 1'b1;
`endif
          end else begin
            reg_d   = i_dbg_reg;
            wdat_d  = i_dbg_wdat;
            state_d = i_dbg_we ? S_WR : S_RD;
`ifdef RF_DBG_ARB_ERR_EN
            err_d   = 1'b0;
`endif
          end
        end
      end
      S_WR: begin
        o_ram_waddr = dbg_addr;
        o_ram_raddr = dbg_addr;
        o_ram_wen   = 1'b1;
        o_ram_wdata =
          wdat_q[int'(beat_q)*RF_WIDTH +: RF_WIDTH];
        beat_d = beat_q + BW'(1);
        if (beat_q == BW'(N - 1))
          state_d = S_DONE;
      end
      S_RD: begin
        o_ram_waddr = dbg_addr;
        o_ram_raddr = dbg_addr;
        o_ram_wen   = 1'b0;
        o_ram_wdata = '0;
        if (beat_q != '0)
          rdt_d[(int'(beat_q)-1)*RF_WIDTH +: RF_WIDTH] =
            i_ram_rdata;
        if (beat_q == BW'(N))
          state_d = S_DONE;
        else
          beat_d = beat_q + BW'(1);
      end
      S_DONE: begin
        o_ram_waddr = dbg_addr;
        o_ram_raddr = dbg_addr;
        o_ram_wen   = 1'b0;
        o_ram_wdata = '0;
        post_d      = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
